multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit ALUop that the ALU control decoder consumes, plus all datapath enables and mux selects.
- Supports memory stalls through a ready handshake, flags unsupported opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
resetl  input  1  synchronous active-low reset
opcode  input  11  IR[31:21], stable from end of FETCH until next FETCH
zero  input  1  ALU zero flag, valid in BRANCH state
mem_ready  input  1  memory completes access this cycle
state  output  4  current FSM state encoding
ALUop  output  2  to ALU control: 00 add, 01 pass-B (CBZ), 10 R-type by opcode
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = shifted branch offset
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write
MemtoReg  output  1  writeback source: 1 = MDR, 0 = ALUOut
Reg2Loc  output  1  1 when opcode is STUR or CBZ (combinational from opcode)
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  output  1  PCWrite OR (PCWriteCond AND zero)
illegal_op  output  1  sticky flag: unsupported opcode was decoded
retired  output  CNT_W  count of completed instructions

Behaviour:
- Opcode map:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
- State encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9. Codes 10-15 go to FETCH next cycle, all outputs 0.
- Outputs other than Reg2Loc, pc_en and the mem_ready-gated strobes are Moore decodes of the state register. Any signal not listed for a state is 0.
- Reset: any rising CLK edge with resetl=0 forces state=FETCH, retired=0, illegal_op=0. This applies mid-instruction and overrides mem_ready. No partial writeback or strobe persists past the reset edge.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUop=00 (precompute branch target).
  - Next state: LDUR/STUR → MEMADDR; R-type → EXEC; CBZ → BRANCH; B → JUMP.
  - Any other opcode → FETCH with illegal_op set to 1. No increment of retired.
- MEMADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Next state: LDUR → MEMRD, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next state RWB.
- RWB: RegWrite=1, MemtoReg=0. Next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
  - pc_en = zero. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Wait-state strobes: MemRead/MemWrite stay asserted for every wait cycle of MEMRD/MEMWR/FETCH. In MEMWR, the write completes only on the mem_ready cycle.
- Retire: retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or JUMP.
  - A CBZ not taken still retires.
  - retired wraps modulo 2^CNT_W.
- Latency with mem_ready=1 throughout:
  - R-type 4 cycles
  - LDUR 5 cycles
  - STUR 4 cycles
  - CBZ 3 cycles
  - B 3 cycles

Test Plan:
- ADD 10001011000, mem_ready=1:
  - state sequence 0,1,6,7,0.
  - ALUop=10 only in EXEC; RegWrite=1 only in RWB.
  - retired 0→1.
- LDUR 11111000010, mem_ready low 2 cycles in MEMRD:
  - state sequence 0,1,2,3,3,3,4,0.
  - MemRead=1, IorD=1 in all three MEMRD cycles.
  - MemtoReg=1 and RegWrite=1 in MEMWB.
- CBZ 10110100000:
  - zero=1: pc_en=1 and ALUop=01 in BRANCH.
  - zero=0: pc_en=0 in BRANCH.
  - retired increments in both cases.
- Opcode 11111111111 in DECODE:
  - next state FETCH, illegal_op=1 and stays 1.
  - retired unchanged.
  - Following SUB executes normally, ALUop=10 in EXEC.
- STUR with mem_ready=0, resetl=0 asserted while in MEMWR:
  - next edge gives state=0, MemWrite=0, retired=0, illegal_op=0.
- FETCH with mem_ready=0 for 3 cycles:
  - IRWrite=0 and pc_en=0 for those cycles.
  - Both assert in the cycle mem_ready=1, then state becomes 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4 on mem_ready
// DECODE  | read registers, precompute branch target
// MEMADDR | compute load/store effective address
// MEMRD   | data read, held until mem_ready
// MEMWB   | write loaded data to register file
// MEMWR   | data write, held until mem_ready
// EXEC    | R-type ALU operation
// RWB     | write ALU result to register file
// BRANCH  | CBZ compare, conditional PC update
// JUMP    | unconditional PC update
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic [1:0]       ALUop,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic [1:0]       PCSource,
  output logic             pc_en,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic is_ldur, is_stur, is_rtype, is_cbz, is_b;
  logic pc_write, pc_write_cond;

  // Opcode classification; CBZ and B ignore their low register/offset bits
  always_comb begin
    is_ldur  = (opcode == OP_LDUR);
    is_stur  = (opcode == OP_STUR);
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_AND) || (opcode == OP_ORR);
    is_cbz   = (opcode[10:3] == 8'b10110100);
    is_b     = (opcode[10:5] == 6'b000101);
    Reg2Loc  = is_stur || is_cbz;
  end

  // State register, retire counter and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, datapath control decode and retire accounting
  always_comb begin
    state_d       = FETCH;
    retired_d     = retired_q;
    illegal_d     = illegal_q;
    ALUop         = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemtoReg      = 1'b0;
    PCSource      = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    unique case (state_q)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (is_ldur || is_stur) state_d = MEMADDR;
        else if (is_rtype)      state_d = EXEC;
        else if (is_cbz)        state_d = BRANCH;
        else if (is_b)          state_d = JUMP;
        else begin
          state_d   = FETCH;
          illegal_d = 1'b1;
        end
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_ldur ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retired_d = retired_q + CNT_W'(1);
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) retired_d = retired_q + CNT_W'(1);
        else           state_d   = MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegWrite  = 1'b1;
        retired_d = retired_q + CNT_W'(1);
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        retired_d     = retired_q + CNT_W'(1);
      end
      JUMP: begin
        pc_write  = 1'b1;
        PCSource  = 2'b10;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = FETCH;
    endcase
  end

  assign pc_en      = pc_write || (pc_write_cond && zero);
  assign state      = state_q;
  assign retired    = retired_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  state;
  logic [1:0]  ALUop, ALUSrcB, PCSource;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg;
  logic        Reg2Loc, pc_en, illegal_op;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .state(state), .ALUop(ALUop),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc),
    .PCSource(PCSource), .pc_en(pc_en), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    resetl = 1'b0; opcode = OP_ADD; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    check_val("rst_state", 32'(state), 0);
    check_val("rst_retired", retired, 0);
    check_val("rst_illegal", 32'(illegal_op), 0);
    resetl = 1'b1;

    // ADD: 0,1,6,7,0
    #1;
    check_val("add_f_state", 32'(state), 0);
    check_val("add_f_memread", 32'(MemRead), 1);
    check_val("add_f_irwrite", 32'(IRWrite), 1);
    check_val("add_f_pcen", 32'(pc_en), 1);
    check_val("add_f_aluop", 32'(ALUop), 0);
    check_val("add_f_srcb", 32'(ALUSrcB), 1);
    tick();
    check_val("add_d_state", 32'(state), 1);
    check_val("add_d_srcb", 32'(ALUSrcB), 3);
    check_val("add_d_aluop", 32'(ALUop), 0);
    check_val("add_d_regwr", 32'(RegWrite), 0);
    check_val("add_reg2loc", 32'(Reg2Loc), 0);
    tick();
    check_val("add_e_state", 32'(state), 6);
    check_val("add_e_aluop", 32'(ALUop), 2);
    check_val("add_e_srca", 32'(ALUSrcA), 1);
    check_val("add_e_srcb", 32'(ALUSrcB), 0);
    check_val("add_e_regwr", 32'(RegWrite), 0);
    tick();
    check_val("add_w_state", 32'(state), 7);
    check_val("add_w_regwr", 32'(RegWrite), 1);
    check_val("add_w_mem2reg", 32'(MemtoReg), 0);
    check_val("add_w_aluop", 32'(ALUop), 0);
    check_val("add_w_retired", retired, 0);
    tick();
    check_val("add_end_state", 32'(state), 0);
    check_val("add_retired", retired, 1);

    // LDUR with two MEMRD wait cycles: 0,1,2,3,3,3,4,0
    opcode = OP_LDUR;
    tick();
    check_val("ld_d_state", 32'(state), 1);
    tick();
    check_val("ld_a_state", 32'(state), 2);
    check_val("ld_a_srca", 32'(ALUSrcA), 1);
    check_val("ld_a_srcb", 32'(ALUSrcB), 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin mem_ready = 1'b1; #1; end
      check_val($sformatf("ld_rd%0d_state", i), 32'(state), 3);
      check_val($sformatf("ld_rd%0d_memread", i), 32'(MemRead), 1);
      check_val($sformatf("ld_rd%0d_iord", i), 32'(IorD), 1);
      check_val($sformatf("ld_rd%0d_regwr", i), 32'(RegWrite), 0);
    end
    tick();
    check_val("ld_wb_state", 32'(state), 4);
    check_val("ld_wb_regwr", 32'(RegWrite), 1);
    check_val("ld_wb_mem2reg", 32'(MemtoReg), 1);
    tick();
    check_val("ld_end_state", 32'(state), 0);
    check_val("ld_retired", retired, 2);

    // CBZ taken
    opcode = OP_CBZ; zero = 1'b1;
    #1;
    check_val("cbz_reg2loc", 32'(Reg2Loc), 1);
    tick();
    tick();
    check_val("cbz1_state", 32'(state), 8);
    check_val("cbz1_pcen", 32'(pc_en), 1);
    check_val("cbz1_aluop", 32'(ALUop), 1);
    check_val("cbz1_pcsrc", 32'(PCSource), 1);
    tick();
    check_val("cbz1_end_state", 32'(state), 0);
    check_val("cbz1_retired", retired, 3);

    // CBZ not taken still retires
    zero = 1'b0;
    tick();
    tick();
    check_val("cbz0_state", 32'(state), 8);
    check_val("cbz0_pcen", 32'(pc_en), 0);
    tick();
    check_val("cbz0_retired", retired, 4);

    // Unsupported opcode, then SUB
    opcode = OP_BAD;
    tick();
    check_val("bad_d_illegal", 32'(illegal_op), 0);
    tick();
    check_val("bad_state", 32'(state), 0);
    check_val("bad_illegal", 32'(illegal_op), 1);
    check_val("bad_retired", retired, 4);
    opcode = OP_SUB;
    tick();
    check_val("sub_d_state", 32'(state), 1);
    tick();
    check_val("sub_e_state", 32'(state), 6);
    check_val("sub_e_aluop", 32'(ALUop), 2);
    tick();
    tick();
    check_val("sub_retired", retired, 5);
    check_val("sub_illegal", 32'(illegal_op), 1);

    // B
    opcode = OP_B;
    tick();
    tick();
    check_val("b_state", 32'(state), 9);
    check_val("b_pcen", 32'(pc_en), 1);
    check_val("b_pcsrc", 32'(PCSource), 2);
    tick();
    check_val("b_retired", retired, 6);

    // STUR stalled in MEMWR, reset mid-instruction
    opcode = OP_STUR;
    tick();
    tick();
    check_val("st_a_state", 32'(state), 2);
    mem_ready = 1'b0;
    tick();
    check_val("st_w_state", 32'(state), 5);
    check_val("st_w_memwr", 32'(MemWrite), 1);
    check_val("st_w_iord", 32'(IorD), 1);
    tick();
    check_val("st_w2_state", 32'(state), 5);
    check_val("st_w2_retired", retired, 6);
    resetl = 1'b0;
    tick();
    check_val("st_rst_state", 32'(state), 0);
    check_val("st_rst_memwr", 32'(MemWrite), 0);
    check_val("st_rst_retired", retired, 0);
    check_val("st_rst_illegal", 32'(illegal_op), 0);
    resetl = 1'b1;

    // FETCH stalled three cycles
    opcode = OP_ADD;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("fs%0d_state", i), 32'(state), 0);
      check_val($sformatf("fs%0d_irwrite", i), 32'(IRWrite), 0);
      check_val($sformatf("fs%0d_pcen", i), 32'(pc_en), 0);
      check_val($sformatf("fs%0d_memread", i), 32'(MemRead), 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_val("fs_go_irwrite", 32'(IRWrite), 1);
    check_val("fs_go_pcen", 32'(pc_en), 1);
    tick();
    check_val("fs_go_state", 32'(state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
